// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit memory controller: funct3 codes,
// controller state encoding and access legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Unsigned widths only make sense for loads, so 1xx on a store is rejected.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        logic bad;
        bad = 1'b1;
        case (f3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic we,
                                        input logic [1:0] addr_lo);
        logic mis;
        mis = f3_illegal(f3, we);
        if (f3[1:0] == 2'b01 && addr_lo[0])
            mis = 1'b1;
        if (f3 == F3_W && addr_lo != 2'b00)
            mis = 1'b1;
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Main-memory request/response bus between the load/store controller (master)
// and the 256-word main memory (slave).
interface lsu_mem_ctrl_if #(
    parameter int MEM_AW = 8
) ();

    logic              mem_request;
    logic              mem_re_we;
    logic [MEM_AW-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic [3:0]        mem_mask;
    logic              mem_valid;
    logic [31:0]       mem_data_out;

    modport master (
        output mem_request, mem_re_we, mem_address, mem_data_in, mem_mask,
        input  mem_valid, mem_data_out
    );

    modport slave (
        input  mem_request, mem_re_we, mem_address, mem_data_in, mem_mask,
        output mem_valid, mem_data_out
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask/replicated data and load extraction with
// sign or zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  mask,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    function automatic logic signed [31:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [31:0] r;
        r = sgn ? {{24{b[7]}}, b} : {24'b0, b};
        return r;
    endfunction

    function automatic logic signed [31:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [31:0] r;
        r = sgn ? {{16{h[15]}}, h} : {16'b0, h};
        return r;
    endfunction

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        rbyte = rword[{addr_lo, 3'b000} +: 8];
        rhalf = rword[{addr_lo[1], 4'b0000} +: 16];
        mask  = 4'b0000;
        wlane = wdata;
        rdata = rword;
        case (funct3)
            F3_B: begin
                mask  = we ? (4'b0001 << addr_lo) : 4'b0000;
                wlane = {4{wdata[7:0]}};
                rdata = ext8(rbyte, 1'b1);
            end
            F3_H: begin
                mask  = we ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b0000;
                wlane = {2{wdata[15:0]}};
                rdata = ext16(rhalf, 1'b1);
            end
            F3_W: begin
                mask  = we ? 4'b1111 : 4'b0000;
                wlane = wdata;
                rdata = rword;
            end
            F3_BU: rdata = ext8(rbyte, 1'b0);
            F3_HU: rdata = ext16(rhalf, 1'b0);
            default: begin
                mask  = 4'b0000;
                wlane = wdata;
                rdata = rword;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store initiator: validates the access, issues one memory
// request, waits for read data with a timeout and reports completion or fault.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEM_AW  = 8,
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_funct3,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        err_misalign,
    output logic        err_fault,
    lsu_mem_ctrl_if.master mem
);

    state_e      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;

    logic        req_misal;
    logic        req_oor;
    logic        al_we;
    logic [2:0]  al_f3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_mask;
    logic [31:0] al_wlane;
    logic [31:0] al_rdata;

    assign req_misal = misaligned(lsu_funct3, lsu_we, lsu_addr[1:0]);
    assign req_oor   = (lsu_addr[31:MEM_AW+2] != '0);
    assign cnt_n     = cnt + 4'd1;

    // In IDLE the aligner shapes the incoming store; afterwards it extracts
    // load data using the latched access attributes.
    assign al_we      = (state == S_IDLE) ? lsu_we            : we_q;
    assign al_f3      = (state == S_IDLE) ? lsu_funct3        : f3_q;
    assign al_addr_lo = (state == S_IDLE) ? lsu_addr[1:0]     : addr_lo_q;

    lsu_lane_align u_align (
        .we      (al_we),
        .funct3  (al_f3),
        .addr_lo (al_addr_lo),
        .wdata   (lsu_wdata),
        .rword   (mem.mem_data_out),
        .mask    (al_mask),
        .wlane   (al_wlane),
        .rdata   (al_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            we_q            <= 1'b0;
            f3_q            <= 3'b000;
            addr_lo_q       <= 2'b00;
            cnt             <= 4'd0;
            busy            <= 1'b0;
            lsu_done        <= 1'b0;
            lsu_rdata       <= 32'd0;
            err_misalign    <= 1'b0;
            err_fault       <= 1'b0;
            mem.mem_request <= 1'b0;
            mem.mem_re_we   <= 1'b0;
            mem.mem_address <= '0;
            mem.mem_data_in <= 32'd0;
            mem.mem_mask    <= 4'b0000;
        end else begin
            lsu_done        <= 1'b0;
            mem.mem_request <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (lsu_req) begin
                        we_q      <= lsu_we;
                        f3_q      <= lsu_funct3;
                        addr_lo_q <= lsu_addr[1:0];
                        busy      <= 1'b1;
                        if (req_misal) begin
                            state        <= S_DONE;
                            lsu_done     <= 1'b1;
                            err_misalign <= 1'b1;
                            lsu_rdata    <= 32'd0;
                        end else if (req_oor) begin
                            state     <= S_DONE;
                            lsu_done  <= 1'b1;
                            err_fault <= 1'b1;
                            lsu_rdata <= 32'd0;
                        end else begin
                            state           <= S_ISSUE;
                            mem.mem_request <= 1'b1;
                            mem.mem_re_we   <= lsu_we;
                            mem.mem_address <= lsu_addr[MEM_AW+1:2];
                            mem.mem_mask    <= al_mask;
                            mem.mem_data_in <= al_wlane;
                        end
                    end
                end
                S_ISSUE: begin
                    // Writes are fire-and-forget; the memory never acknowledges them.
                    if (we_q) begin
                        state    <= S_DONE;
                        lsu_done <= 1'b1;
                    end else begin
                        state <= S_WAIT;
                        cnt   <= 4'd0;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_valid) begin
                        state     <= S_DONE;
                        lsu_done  <= 1'b1;
                        lsu_rdata <= al_rdata;
                    end else if (cnt_n == 4'(TIMEOUT)) begin
                        state     <= S_DONE;
                        lsu_done  <= 1'b1;
                        err_fault <= 1'b1;
                        lsu_rdata <= 32'd0;
                        cnt       <= 4'd0;
                    end else begin
                        cnt <= cnt_n;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    busy         <= 1'b0;
                    err_misalign <= 1'b0;
                    err_fault    <= 1'b0;
                    cnt          <= 4'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a registered-response memory model.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        err_misalign;
    logic        err_fault;

    int vectors = 0;
    int miscompares = 0;

    lsu_mem_ctrl_if #(.MEM_AW(8)) m ();

    lsu_mem_ctrl #(.MEM_AW(8), .TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_req      (lsu_req),
        .lsu_we       (lsu_we),
        .lsu_funct3   (lsu_funct3),
        .lsu_addr     (lsu_addr),
        .lsu_wdata    (lsu_wdata),
        .busy         (busy),
        .lsu_done     (lsu_done),
        .lsu_rdata    (lsu_rdata),
        .err_misalign (err_misalign),
        .err_fault    (err_fault),
        .mem          (m)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle registered read response, masked byte writes.
    logic [31:0] mem_arr [256];
    logic        hold_invalid = 1'b0;
    int          req_cnt;
    logic [7:0]  last_addr;
    logic        last_re_we;
    logic [3:0]  last_mask;
    logic [31:0] last_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m.mem_valid    <= 1'b0;
            m.mem_data_out <= 32'd0;
            mem_arr[5]     <= 32'h8899AABB;
            mem_arr[8]     <= 32'h11223344;
        end else begin
            m.mem_valid <= 1'b0;
            if (m.mem_request) begin
                req_cnt    <= req_cnt + 1;
                last_addr  <= m.mem_address;
                last_re_we <= m.mem_re_we;
                last_mask  <= m.mem_mask;
                last_data  <= m.mem_data_in;
                if (m.mem_re_we) begin
                    for (int b = 0; b < 4; b++)
                        if (m.mem_mask[b])
                            mem_arr[m.mem_address][8*b +: 8] <= m.mem_data_in[8*b +: 8];
                end else if (!hold_invalid) begin
                    m.mem_data_out <= mem_arr[m.mem_address];
                    m.mem_valid    <= 1'b1;
                end
            end
        end
    end

    task automatic do_access(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output logic [31:0] rd,
                             output logic em, output logic ef, output int nreq);
        int r0;
        bit seen;
        r0 = req_cnt;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wdata;
        @(posedge clk); #1;
        lsu_req = 1'b0;
        lat = -1; rd = 32'hDEADDEAD; em = 1'bx; ef = 1'bx; seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (lsu_done === 1'b1) begin
                lat = k; rd = lsu_rdata; em = err_misalign; ef = err_fault; seen = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        nreq = req_cnt - r0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_after_done: got %b want 0", busy);
        end
    endtask

    task automatic chk_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp_rd);
        int lat, nreq; logic [31:0] rd; logic em, ef;
        do_access(1'b0, f3, addr, 32'd0, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 3 || rd !== exp_rd || em !== 1'b0 || ef !== 1'b0 || nreq !== 1) begin
            miscompares++;
            $display("FAIL %s: lat=%0d rd=%h em=%b ef=%b nreq=%0d want lat=3 rd=%h em=0 ef=0 nreq=1",
                     name, lat, rd, em, ef, nreq, exp_rd);
        end
        vectors++;
        if (last_addr !== addr[9:2] || last_re_we !== 1'b0 || last_mask !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s_bus: addr=%0d re_we=%b mask=%b want addr=%0d re_we=0 mask=0000",
                     name, last_addr, last_re_we, last_mask, addr[9:2]);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        logic [80:0] all;
        all = {busy, lsu_done, lsu_rdata, err_misalign, err_fault, m.mem_request,
               m.mem_re_we, m.mem_address, m.mem_mask, 4'b0, |m.mem_data_in};
        vectors++;
        if (all !== '0) begin
            miscompares++;
            $display("FAIL %s: busy=%b done=%b rdata=%h em=%b ef=%b req=%b re_we=%b addr=%h mask=%b din=%h want all 0",
                     name, busy, lsu_done, lsu_rdata, err_misalign, err_fault, m.mem_request,
                     m.mem_re_we, m.mem_address, m.mem_mask, m.mem_data_in);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_funct3 = 3'b000; lsu_addr = 32'd0; lsu_wdata = 32'd0;
        req_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_loads();
        chk_load("lw_0x14",  F3_W,  32'h14, 32'h8899AABB);
        chk_load("lb_0x17",  F3_B,  32'h17, 32'hFFFFFF88);
        chk_load("lbu_0x17", F3_BU, 32'h17, 32'h00000088);
        chk_load("lhu_0x16", F3_HU, 32'h16, 32'h00008899);
        chk_load("lh_0x14",  F3_H,  32'h14, 32'hFFFFAABB);
        chk_load("lbu_0x14", F3_BU, 32'h14, 32'h000000BB);
    endtask

    task automatic test_stores();
        int lat, nreq; logic [31:0] rd; logic em, ef;
        do_access(1'b1, F3_H, 32'h22, 32'h1234CAFE, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 2 || em !== 1'b0 || ef !== 1'b0 || nreq !== 1) begin
            miscompares++;
            $display("FAIL sh_0x22: lat=%0d em=%b ef=%b nreq=%0d want lat=2 em=0 ef=0 nreq=1",
                     lat, em, ef, nreq);
        end
        vectors++;
        if (last_addr !== 8'd8 || last_re_we !== 1'b1 || last_mask !== 4'b1100 ||
            last_data !== 32'hCAFECAFE) begin
            miscompares++;
            $display("FAIL sh_0x22_bus: addr=%0d re_we=%b mask=%b din=%h want 8 1 1100 cafecafe",
                     last_addr, last_re_we, last_mask, last_data);
        end
        chk_load("lw_after_sh", F3_W, 32'h20, 32'hCAFE3344);

        do_access(1'b1, F3_B, 32'h21, 32'h000000A5, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 2 || last_mask !== 4'b0010 || last_data !== 32'hA5A5A5A5 || nreq !== 1) begin
            miscompares++;
            $display("FAIL sb_0x21: lat=%0d mask=%b din=%h nreq=%0d want 2 0010 a5a5a5a5 1",
                     lat, last_mask, last_data, nreq);
        end
        chk_load("lw_after_sb", F3_W, 32'h20, 32'hCAFEA544);

        do_access(1'b1, F3_W, 32'h24, 32'h0BADF00D, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 2 || last_mask !== 4'b1111 || last_data !== 32'h0BADF00D || last_addr !== 8'd9) begin
            miscompares++;
            $display("FAIL sw_0x24: lat=%0d mask=%b din=%h addr=%0d want 2 1111 0badf00d 9",
                     lat, last_mask, last_data, last_addr);
        end
    endtask

    task automatic test_early_errors();
        int lat, nreq; logic [31:0] rd; logic em, ef;
        do_access(1'b0, F3_W, 32'h13, 32'd0, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 1 || em !== 1'b1 || ef !== 1'b0 || nreq !== 0) begin
            miscompares++;
            $display("FAIL lw_misalign: lat=%0d em=%b ef=%b nreq=%0d want 1 1 0 0", lat, em, ef, nreq);
        end
        do_access(1'b0, F3_H, 32'h15, 32'd0, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 1 || em !== 1'b1 || ef !== 1'b0 || nreq !== 0) begin
            miscompares++;
            $display("FAIL lh_misalign: lat=%0d em=%b ef=%b nreq=%0d want 1 1 0 0", lat, em, ef, nreq);
        end
        do_access(1'b0, 3'b011, 32'h14, 32'd0, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 1 || em !== 1'b1 || nreq !== 0) begin
            miscompares++;
            $display("FAIL f3_011: lat=%0d em=%b nreq=%0d want 1 1 0", lat, em, nreq);
        end
        do_access(1'b1, F3_BU, 32'h14, 32'd0, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 1 || em !== 1'b1 || nreq !== 0) begin
            miscompares++;
            $display("FAIL store_bu: lat=%0d em=%b nreq=%0d want 1 1 0", lat, em, nreq);
        end
        do_access(1'b0, F3_W, 32'h400, 32'd0, lat, rd, em, ef, nreq);
        vectors++;
        if (lat !== 1 || em !== 1'b0 || ef !== 1'b1 || nreq !== 0) begin
            miscompares++;
            $display("FAIL lw_oor: lat=%0d em=%b ef=%b nreq=%0d want 1 0 1 0", lat, em, ef, nreq);
        end
    endtask

    task automatic test_timeout();
        int lat, nreq; logic [31:0] rd; logic em, ef;
        hold_invalid = 1'b1;
        do_access(1'b0, F3_W, 32'h14, 32'd0, lat, rd, em, ef, nreq);
        hold_invalid = 1'b0;
        vectors++;
        if (lat !== 6 || ef !== 1'b1 || em !== 1'b0 || rd !== 32'd0 || nreq !== 1) begin
            miscompares++;
            $display("FAIL timeout: lat=%0d ef=%b em=%b rd=%h nreq=%0d want 6 1 0 0 1",
                     lat, ef, em, rd, nreq);
        end
    endtask

    task automatic test_reset_mid();
        bit saw_done;
        chk_load("lw_before_rst", F3_BU, 32'h15, 32'h000000AA);
        hold_invalid = 1'b1;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = F3_W; lsu_addr = 32'h14;
        @(posedge clk); #1;
        lsu_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_in_wait: got %b want 1", busy);
        end
        #2 rst = 1'b1;
        #1;
        chk_outputs_zero("async_reset_mid");
        @(negedge clk);
        rst = 1'b0;
        hold_invalid = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (lsu_done === 1'b1 || busy !== 1'b0) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL no_done_after_rst: got activity want none");
        end
        chk_load("lw_after_rst", F3_W, 32'h14, 32'h8899AABB);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_early_errors();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
